chicken_turn_fsm: RTL and testbench
===================================

Name: chicken_turn_fsm

Overview:
- Per-turn game controller for the Chicken Cha Cha Cha board game.
- Takes the current player's card flips and compares each revealed picture with the picture on the tile ahead of that player's chicken.
- Advances the chicken on a match. On a miss, issues the one-cycle next-turn pulse consumed by the turn counter, whose 2-bit turn output returns here as cur_turn.
- Tracks the step count of every player and detects the winner.

Parameters:
- REVEAL_CYCLES, 50000000, clock cycles a flipped card stays shown before judging (1 s at 50 MHz); range 1..2^26-1.
- BOARD_LEN, 24, steps a chicken must take to win; range 1..31.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a game from IDLE or OVER
- num_players  input  2  00=2, 01=3, 10=4 players; 11 treated as 00; latched on start
- cur_turn  input  2  current player index from the turn counter
- flip  input  1  one-cycle pulse; card_sel valid
- card_sel  input  4  selected card index, 0..11
- card_pic  input  4  picture under card_sel, from card ROM, valid in the same cycle as flip
- target_pic  input  4  picture of the tile ahead of the current chicken, from board ROM indexed by cur_pos
- next_turn  output  1  one-cycle registered pulse to the turn counter
- cur_pos  output  5  step count of player cur_turn (combinational select)
- revealed  output  12  bitmask of cards face-up this turn
- reveal_active  output  1  high while in SHOW
- game_over  output  1  high in OVER
- winner  output  2  index of the winning player; valid while game_over=1
- state  output  3  current FSM state, for debug LEDs

Behaviour:
- Reset (rst=0, async): state=IDLE, steps[0..3]=0, revealed=0, pic_q=0, timer=0, next_turn=0, game_over=0, winner=0. Takes effect immediately from any state, including SHOW.
- State encoding: IDLE=0, PICK=1, SHOW=2, JUDGE=3, ADVANCE=4, PASS=5, OVER=6.
- IDLE: when start=1, latch num_players, clear steps and revealed, and go to PICK. All other inputs are ignored.
- PICK: a flip is accepted only if flip=1, card_sel<12 and revealed[card_sel]=0. On acceptance:
  - pic_q <= card_pic
  - set revealed[card_sel]
  - timer <= REVEAL_CYCLES-1
  - go to SHOW
  - Any other flip is ignored and the state holds.
- SHOW: reveal_active=1. Timer decrements each cycle; at timer=0 go to JUDGE, so SHOW lasts exactly REVEAL_CYCLES cycles. Flips are ignored.
- JUDGE (1 cycle): if pic_q==target_pic go to ADVANCE, else go to PASS.
- ADVANCE (1 cycle): steps[cur_turn] <= steps[cur_turn]+1.
  - If the new value equals BOARD_LEN: winner <= cur_turn and go to OVER.
  - Else if revealed is all ones (no card left to pick): go to PASS.
  - Else go to PICK; revealed cards stay face-up.
- PASS (1 cycle): next_turn=1 for exactly this cycle, registered so it rises on the clock edge; revealed <= 0; go to PICK. cur_turn is not sampled again until JUDGE, at least REVEAL_CYCLES+2 cycles later, which covers the turn counter update.
- OVER: game_over=1, winner holds, flips are ignored. When start=1, clear steps, revealed and winner, relatch num_players, and go to PICK. The turn counter is not reset by this block.
- start is ignored in PICK..PASS.
- Steps are 5-bit and saturate at BOARD_LEN; no wrap.
- steps entries for indices ≥ the player count stay 0 and are never addressed in normal play.
- next_turn is never asserted outside PASS.
- The 11 encoding of num_players must behave identically to 00.

Test Plan:
1. Reset and start: rst=0 for 3 cycles → state=0, all outputs 0. Release rst, pulse start → state=1 on the next cycle, revealed=0.
2. Match (REVEAL_CYCLES=4, cur_turn=0): flip with card_sel=3, card_pic=5, target_pic=5 → reveal_active high exactly 4 cycles, revealed=12'h008, then JUDGE, then ADVANCE; cur_pos=1, state back to 1, next_turn stays 0.
3. Miss: continuing from scenario 2, flip with card_sel=7, card_pic=2, target_pic=5 → after SHOW+JUDGE, next_turn=1 for exactly 1 cycle, revealed=0 the following cycle, state=1.
4. Illegal flips in PICK: card_sel=3 with revealed[3]=1 → no change. card_sel=12 → no change. flip during SHOW → no effect on revealed or timer.
5. Win (BOARD_LEN=2, cur_turn=2, num_players=10): two consecutive matches → game_over=1, winner=2, state=6, later flips ignored. Pulse start → state=1, cur_pos=0, game_over=0.
6. Reset mid-operation: assert rst=0 two cycles into SHOW → state=0, reveal_active=0, revealed=0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/chicken_turn_fsm.sv
// Per-turn controller for Chicken Cha Cha Cha: judges card flips against the tile
// ahead of the current chicken, advances on a match and hands the turn on a miss.
module chicken_turn_fsm #(
  parameter int unsigned REVEAL_CYCLES = 50000000,
  parameter int unsigned BOARD_LEN     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  num_players,
  input  logic [1:0]  cur_turn,
  input  logic        flip,
  input  logic [3:0]  card_sel,
  input  logic [3:0]  card_pic,
  input  logic [3:0]  target_pic,
  output logic        next_turn,
  output logic [4:0]  cur_pos,
  output logic [11:0] revealed,
  output logic        reveal_active,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  localparam logic [25:0] TimerLoad = 26'(REVEAL_CYCLES - 1);
  localparam logic [4:0]  BoardLen  = 5'(BOARD_LEN);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPick    = 3'd1,
    StShow    = 3'd2,
    StJudge   = 3'd3,
    StAdvance = 3'd4,
    StPass    = 3'd5,
    StOver    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  steps_q [4];
  logic [4:0]  steps_d [4];
  logic [11:0] revealed_q, revealed_d;
  logic [3:0]  pic_q, pic_d;
  logic [25:0] timer_q, timer_d;
  logic [1:0]  np_q, np_d;  // 0: two players, 1: three, 2: four
  logic [1:0]  winner_q, winner_d;
  logic        next_turn_q, next_turn_d;

  logic [15:0] rev_ext;
  logic        flip_ok;
  logic [2:0]  n_players;
  logic        turn_valid;
  logic [4:0]  step_new;

  always_comb begin
    rev_ext    = {4'b0000, revealed_q};
    flip_ok    = flip && (card_sel < 4'd12) && !rev_ext[card_sel];
    n_players  = 3'd2 + {1'b0, np_q};
    turn_valid = ({1'b0, cur_turn} < n_players);
    step_new   = (steps_q[cur_turn] < BoardLen) ? steps_q[cur_turn] + 5'd1 : steps_q[cur_turn];
  end

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    revealed_d = revealed_q;
    pic_d      = pic_q;
    timer_d    = timer_q;
    np_d       = np_q;
    winner_d   = winner_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          np_d       = (num_players == 2'b11) ? 2'b00 : num_players;
          steps_d    = '{default: 5'd0};
          revealed_d = '0;
          state_d    = StPick;
        end
      end
      StPick: begin
        if (flip_ok) begin
          pic_d      = card_pic;
          revealed_d = revealed_q | 12'(16'd1 << card_sel);
          timer_d    = TimerLoad;
          state_d    = StShow;
        end
      end
      StShow: begin
        if (timer_q == '0) begin
          state_d = StJudge;
        end else begin
          timer_d = timer_q - 26'd1;
        end
      end
      StJudge: begin
        state_d = (pic_q == target_pic) ? StAdvance : StPass;
      end
      StAdvance: begin
        // Seats beyond the latched player count never move
        if (turn_valid) begin
          steps_d[cur_turn] = step_new;
        end
        if (turn_valid && (step_new == BoardLen)) begin
          winner_d = cur_turn;
          state_d  = StOver;
        end else if (&revealed_q) begin
          state_d = StPass;
        end else begin
          state_d = StPick;
        end
      end
      StPass: begin
        revealed_d = '0;
        state_d    = StPick;
      end
      StOver: begin
        if (start) begin
          np_d       = (num_players == 2'b11) ? 2'b00 : num_players;
          steps_d    = '{default: 5'd0};
          revealed_d = '0;
          winner_d   = '0;
          state_d    = StPick;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so the pulse coincides exactly with the PASS cycle
    next_turn_d = (state_d == StPass);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      steps_q     <= '{default: 5'd0};
      revealed_q  <= '0;
      pic_q       <= '0;
      timer_q     <= '0;
      np_q        <= '0;
      winner_q    <= '0;
      next_turn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      revealed_q  <= revealed_d;
      pic_q       <= pic_d;
      timer_q     <= timer_d;
      np_q        <= np_d;
      winner_q    <= winner_d;
      next_turn_q <= next_turn_d;
    end
  end

  assign state         = state_q;
  assign next_turn     = next_turn_q;
  assign cur_pos       = steps_q[cur_turn];
  assign revealed      = revealed_q;
  assign reveal_active = (state_q == StShow);
  assign game_over     = (state_q == StOver);
  assign winner        = winner_q;

endmodule

// File: tb/tb_chicken_turn_fsm.sv
// Bench for chicken_turn_fsm: every state change is an output event checked against a queue
// of hand-computed snapshots, including how many cycles the previous state lasted.
module tb_chicken_turn_fsm;

  localparam logic [2:0] StIdle = 3'd0, StPick = 3'd1, StShow = 3'd2, StJudge = 3'd3,
                         StAdvance = 3'd4, StPass = 3'd5, StOver = 3'd6;

  logic        clk = 1'b0;
  logic        rst, start, flip;
  logic [1:0]  num_players, cur_turn;
  logic [3:0]  card_sel, card_pic, target_pic;
  logic        next_turn, reveal_active, game_over;
  logic [4:0]  cur_pos;
  logic [11:0] revealed;
  logic [1:0]  winner;
  logic [2:0]  state;

  chicken_turn_fsm #(
    .REVEAL_CYCLES(4),
    .BOARD_LEN    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_players  (num_players),
    .cur_turn     (cur_turn),
    .flip         (flip),
    .card_sel     (card_sel),
    .card_pic     (card_pic),
    .target_pic   (target_pic),
    .next_turn    (next_turn),
    .cur_pos      (cur_pos),
    .revealed     (revealed),
    .reveal_active(reveal_active),
    .game_over    (game_over),
    .winner       (winner),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] rev;
    logic [4:0]  pos;
    logic        nt;
    logic        ra;
    logic        go;
    logic [1:0]  win;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
    int    dwell;  // cycles spent in the previous state, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push(input string n, input logic [2:0] st, input logic [11:0] rev,
                               input logic [4:0] pos, input logic nt, input logic go,
                               input logic [1:0] win, input int dw);
    exp_t e;
    e.name  = n;
    e.s     = '{st: st, rev: rev, pos: pos, nt: nt, ra: (st == StShow), go: go, win: win};
    e.dwell = dw;
    exp_q.push_back(e);
  endfunction

  // Monitor: samples after every falling clock edge and after a reset assertion
  initial begin
    logic [2:0] prev_st;
    int         cnt;
    snap_t      cur;
    exp_t       e;
    prev_st = 3'd7;
    cnt     = 0;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      cur = '{st: state, rev: revealed, pos: cur_pos, nt: next_turn, ra: reveal_active,
              go: game_over, win: winner};
      if (cur.st != prev_st) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got st=%0d rev=%h pos=%0d, required no event",
                   cur.st, cur.rev, cur.pos);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.s || (e.dwell >= 0 && cnt != e.dwell)) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rev=%h pos=%0d nt=%0b ra=%0b go=%0b win=%0d dwell=%0d, required st=%0d rev=%h pos=%0d nt=%0b ra=%0b go=%0b win=%0d dwell=%0d",
                     e.name, cur.st, cur.rev, cur.pos, cur.nt, cur.ra, cur.go, cur.win, cnt,
                     e.s.st, e.s.rev, e.s.pos, e.s.nt, e.s.ra, e.s.go, e.s.win, e.dwell);
          end
        end
        prev_st = cur.st;
        cnt     = (clk == 1'b0) ? 1 : 0;
      end else if (clk == 1'b0) begin
        cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_flip(input logic [3:0] sel, input logic [3:0] pic);
    card_sel = sel;
    card_pic = pic;
    flip     = 1'b1;
    tick();
    flip     = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (state !== s && k < 50) begin
      tick();
      k++;
    end
    if (state !== s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_state: got st=%0d, required st=%0d within 50 cycles", state, s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_players = 2'b00; cur_turn = 2'd0;
    flip = 1'b0; card_sel = '0; card_pic = '0; target_pic = '0;

    // Reset and start
    push("reset", StIdle, 12'h000, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    push("start", StPick, 12'h000, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;

    // Match for player 0
    push("match_show",  StShow,    12'h008, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    push("match_judge", StJudge,   12'h008, 5'd0, 1'b0, 1'b0, 2'd0, 4);
    push("match_adv",   StAdvance, 12'h008, 5'd0, 1'b0, 1'b0, 2'd0, 1);
    push("match_pick",  StPick,    12'h008, 5'd1, 1'b0, 1'b0, 2'd0, 1);
    target_pic = 4'd5;
    drive_flip(4'd3, 4'd5);
    wait_state(StPick);

    // Illegal flips: already face-up, out of range
    drive_flip(4'd3, 4'd5);
    drive_flip(4'd12, 4'd5);

    // Miss, with an ignored flip during SHOW
    push("miss_show",  StShow,  12'h088, 5'd1, 1'b0, 1'b0, 2'd0, -1);
    push("miss_judge", StJudge, 12'h088, 5'd1, 1'b0, 1'b0, 2'd0, 4);
    push("miss_pass",  StPass,  12'h088, 5'd1, 1'b1, 1'b0, 2'd0, 1);
    push("miss_pick",  StPick,  12'h000, 5'd1, 1'b0, 1'b0, 2'd0, 1);
    drive_flip(4'd7, 4'd2);
    tick();
    drive_flip(4'd9, 4'd2);
    wait_state(StPick);

    // Asynchronous reset two cycles into SHOW
    push("rst_show", StShow, 12'h001, 5'd1, 1'b0, 1'b0, 2'd0, -1);
    push("rst_mid",  StIdle, 12'h000, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    drive_flip(4'd0, 4'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Four players, player 2 wins with two matches
    num_players = 2'b10;
    cur_turn    = 2'd2;
    target_pic  = 4'd6;
    push("start4", StPick, 12'h000, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    push("win1_show",  StShow,    12'h010, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    push("win1_judge", StJudge,   12'h010, 5'd0, 1'b0, 1'b0, 2'd0, 4);
    push("win1_adv",   StAdvance, 12'h010, 5'd0, 1'b0, 1'b0, 2'd0, 1);
    push("win1_pick",  StPick,    12'h010, 5'd1, 1'b0, 1'b0, 2'd0, 1);
    drive_flip(4'd4, 4'd6);
    wait_state(StPick);
    push("win2_show",  StShow,    12'h030, 5'd1, 1'b0, 1'b0, 2'd0, -1);
    push("win2_judge", StJudge,   12'h030, 5'd1, 1'b0, 1'b0, 2'd0, 4);
    push("win2_adv",   StAdvance, 12'h030, 5'd1, 1'b0, 1'b0, 2'd0, 1);
    push("win_over",   StOver,    12'h030, 5'd2, 1'b0, 1'b1, 2'd2, 1);
    drive_flip(4'd5, 4'd6);
    wait_state(StOver);

    // Flips in OVER are ignored; start begins a new game
    drive_flip(4'd6, 4'd6);
    drive_flip(4'd7, 4'd6);
    push("restart", StPick, 12'h000, 5'd0, 1'b0, 1'b0, 2'd0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL events_missing: got %0d unmatched expectations, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
